// File: rtl/spio_hss_multiplexer_chan_arbiter_pkg.sv
// Shared defaults and helpers for the HSS multiplexer channel arbiter.
//   DEF_*      : default parameter values used by the arbiter and its FIFOs
//   chan_bits  : width of a channel index (at least 1 bit)
//   wrap_inc   : modulo-n increment used by the round-robin pointer
package spio_hss_multiplexer_chan_arbiter_pkg;

  localparam int DEF_NUM_CHANS = 8;
  localparam int DEF_PKT_BITS  = 72;
  localparam int DEF_FIFO_LOG2 = 2;
  localparam int DEF_MAX_CRDT  = 15;
  localparam int DEF_CRDT_BITS = 4;

  function automatic int chan_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int wrap_inc(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/spio_hss_multiplexer_chan_arbiter_fifo.sv
// Per-channel packet FIFO: circular buffer with one extra pointer bit so
// full and empty are distinguished by the pointer MSBs.
//   clk, rst      : clock, synchronous active-high reset
//   push_i        : write push_data_i (ignored while full)
//   pop_i         : drop the head entry (ignored while empty)
//   head_data_o   : current head entry (valid while !empty_o)
//   empty_o       : no entries held
//   full_o        : 2**FIFO_LOG2 entries held
module spio_hss_multiplexer_chan_fifo #(
  parameter int PKT_BITS  = 72,
  parameter int FIFO_LOG2 = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push_i,
  input  logic [PKT_BITS-1:0] push_data_i,
  input  logic                pop_i,
  output logic [PKT_BITS-1:0] head_data_o,
  output logic                empty_o,
  output logic                full_o
);

  localparam int DEPTH = 1 << FIFO_LOG2;

  logic [FIFO_LOG2:0]  wr_ptr_q, wr_ptr_d;
  logic [FIFO_LOG2:0]  rd_ptr_q, rd_ptr_d;
  logic [PKT_BITS-1:0] mem_q [DEPTH];
  logic                push_ok, pop_ok;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[FIFO_LOG2] != rd_ptr_q[FIFO_LOG2]) &&
                   (wr_ptr_q[FIFO_LOG2-1:0] == rd_ptr_q[FIFO_LOG2-1:0]);

  // A push while full is refused even if a pop happens on the same edge,
  // because the upstream ready was already low.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Shallow buffer with an asynchronous head read, so a packet written on
  // one edge can be granted on the very next edge.
  assign head_data_o = mem_q[rd_ptr_q[FIFO_LOG2-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[FIFO_LOG2-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/spio_hss_multiplexer_chan_arbiter.sv
// N-channel packet front end for the HSS multiplexer transmit path.
// Buffers packets per channel, honours remote channel flow control, gates
// on a frame-credit counter and round-robin arbitrates into a single output
// register tagged with the source channel.
//   clk, rst                 : clock, synchronous active-high reset
//   pkt_data/pkt_vld/pkt_rdy : per-channel input handshake
//   cfc_rem                  : remote stop per channel (blocks new grants)
//   crdt_ret_vld/_cnt        : credit return
//   out_data/out_chan/out_vld/out_rdy : output register handshake
//   reg_crdt/reg_empt/reg_full/reg_looc : status
module spio_hss_multiplexer_chan_arbiter
  import spio_hss_multiplexer_chan_arbiter_pkg::*;
#(
  parameter int NUM_CHANS = DEF_NUM_CHANS,
  parameter int PKT_BITS  = DEF_PKT_BITS,
  parameter int FIFO_LOG2 = DEF_FIFO_LOG2,
  parameter int MAX_CRDT  = DEF_MAX_CRDT,
  parameter int CRDT_BITS = DEF_CRDT_BITS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CHANS*PKT_BITS-1:0] pkt_data,
  input  logic [NUM_CHANS-1:0]          pkt_vld,
  output logic [NUM_CHANS-1:0]          pkt_rdy,
  input  logic [NUM_CHANS-1:0]          cfc_rem,
  input  logic                          crdt_ret_vld,
  input  logic [CRDT_BITS-1:0]          crdt_ret_cnt,
  output logic [PKT_BITS-1:0]           out_data,
  output logic [$clog2(NUM_CHANS)-1:0]  out_chan,
  output logic                          out_vld,
  input  logic                          out_rdy,
  output logic [CRDT_BITS-1:0]          reg_crdt,
  output logic [NUM_CHANS-1:0]          reg_empt,
  output logic [NUM_CHANS-1:0]          reg_full,
  output logic                          reg_looc
);

  localparam int CHAN_BITS = chan_bits(NUM_CHANS);
  localparam logic [CRDT_BITS:0]   MAX_WIDE = (CRDT_BITS+1)'(MAX_CRDT);
  localparam logic [CRDT_BITS-1:0] MAX_NARW = CRDT_BITS'(MAX_CRDT);

  logic [NUM_CHANS-1:0] fifo_empty;
  logic [NUM_CHANS-1:0] fifo_full;
  logic [NUM_CHANS-1:0] fifo_pop;
  logic [PKT_BITS-1:0]  head_data [NUM_CHANS];

  logic [NUM_CHANS-1:0] eligible;
  logic [CHAN_BITS-1:0] grant_idx;
  logic                 grant_any;
  logic                 load;

  logic                 out_vld_q, out_vld_d;
  logic [PKT_BITS-1:0]  out_data_q, out_data_d;
  logic [CHAN_BITS-1:0] out_chan_q, out_chan_d;
  logic [CHAN_BITS-1:0] rr_ptr_q, rr_ptr_d;
  logic [CRDT_BITS-1:0] crdt_q, crdt_d;
  logic [CRDT_BITS:0]   crdt_sum;

  // ---------------- per-channel FIFOs ----------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHANS; gi++) begin : g_chan
      assign fifo_pop[gi] = load && (grant_idx == CHAN_BITS'(gi));

      spio_hss_multiplexer_chan_fifo #(
        .PKT_BITS  (PKT_BITS),
        .FIFO_LOG2 (FIFO_LOG2)
      ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (pkt_vld[gi] & pkt_rdy[gi]),
        .push_data_i (pkt_data[gi*PKT_BITS +: PKT_BITS]),
        .pop_i       (fifo_pop[gi]),
        .head_data_o (head_data[gi]),
        .empty_o     (fifo_empty[gi]),
        .full_o      (fifo_full[gi])
      );
    end
  endgenerate

  // Ready comes straight from pointer flops: no vld->rdy combinational path.
  assign pkt_rdy  = ~fifo_full;
  assign reg_empt = fifo_empty;
  assign reg_full = fifo_full;
  assign reg_crdt = crdt_q;
  assign reg_looc = (crdt_q == '0) && |(~fifo_empty & ~cfc_rem);

  // ---------------- round-robin arbiter ----------------
  assign eligible = ~fifo_empty & ~cfc_rem & {NUM_CHANS{crdt_q != '0}};

  // Scan from the farthest offset down to rr_ptr itself so the closest
  // eligible channel at or after the pointer is the one left standing.
  always_comb begin
    int idx;
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int off = NUM_CHANS - 1; off >= 0; off--) begin
      idx = int'(rr_ptr_q) + off;
      if (idx >= NUM_CHANS) idx = idx - NUM_CHANS;
      if (eligible[idx]) begin
        grant_any = 1'b1;
        grant_idx = CHAN_BITS'(idx);
      end
    end
  end

  assign load = (~out_vld_q | out_rdy) & grant_any;

  // ---------------- output register / pointer ----------------
  always_comb begin
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_chan_d = out_chan_q;
    rr_ptr_d   = rr_ptr_q;
    if (load) begin
      out_vld_d  = 1'b1;
      out_data_d = head_data[grant_idx];
      out_chan_d = grant_idx;
      rr_ptr_d   = CHAN_BITS'(wrap_inc(int'(grant_idx), NUM_CHANS));
    end else if (out_rdy) begin
      out_vld_d  = 1'b0;
    end
  end

  // ---------------- credit counter ----------------
  // One extra bit of headroom so a large return can be saturated; a grant
  // only happens with crdt_q >= 1, so the subtraction never wraps.
  always_comb begin
    crdt_sum = {1'b0, crdt_q};
    if (crdt_ret_vld) crdt_sum = crdt_sum + {1'b0, crdt_ret_cnt};
    if (load)         crdt_sum = crdt_sum - (CRDT_BITS+1)'(1);
    crdt_d = (crdt_sum > MAX_WIDE) ? MAX_NARW : crdt_sum[CRDT_BITS-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_chan_q <= '0;
      rr_ptr_q   <= '0;
      crdt_q     <= MAX_NARW;
    end else begin
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_chan_q <= out_chan_d;
      rr_ptr_q   <= rr_ptr_d;
      crdt_q     <= crdt_d;
    end
  end

  assign out_vld  = out_vld_q;
  assign out_data = out_data_q;
  assign out_chan = out_chan_q[$clog2(NUM_CHANS)-1:0];

endmodule
